imm_gen_stage: RTL and testbench

//   Registered, parametrised immediate generator for the ID/EX boundary of the pipeline.

---
 rtl/imm_gen_stage.sv | 68 ++++++
 tb/tb_imm_gen_stage.sv | 178 +++++++++++++++++
 2 files changed

// File: rtl/imm_gen_stage.sv
// imm_gen_stage: registered immediate decoder with a 2-entry skid buffer at the ID/EX boundary.
// Decode happens before storage so imm_out, out_tag and out_err come straight from the head register.
module imm_gen_stage #(
    parameter int XLEN  = 32,
    parameter int TAG_W = 32
) (
    input  logic             CLK,
    input  logic             RESET,
    input  logic             FLUSH,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [24:0]      instr_bits,
    input  logic [2:0]       imm_sel,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [XLEN-1:0]  imm_out,
    output logic [TAG_W-1:0] out_tag,
    output logic             out_err
);
    localparam int EW = XLEN + TAG_W + 1;
    logic [31:7]     i;
    logic [XLEN-1:0] imm;
    logic            err;
    logic [EW-1:0]   new_e, h_q, h_d, k_q, k_d;
    logic [1:0]      cnt_q, cnt_d;
    logic            push, pop;
    always_comb begin
        i   = instr_bits;
        imm = '0;
        err = 1'b0;
        case (imm_sel)
            3'b000:  imm = XLEN'($signed(i[31:20]));
            3'b001:  imm = XLEN'($signed({i[31:25], i[11:7]}));
            3'b010:  imm = XLEN'($signed({i[31], i[7], i[30:25], i[11:8], 1'b0}));
            3'b011:  imm = XLEN'($signed({i[31:12], 12'b0}));
            3'b100:  imm = XLEN'($signed({i[31], i[19:12], i[20], i[30:21], 1'b0}));
            3'b101:  imm = XLEN'(i[19:15]);
            3'b110:  imm = (XLEN == 64) ? XLEN'(i[25:20]) : XLEN'(i[24:20]);
            default: err = 1'b1;
        endcase
    end
    // in_ready depends only on the registered count, never on out_ready
    assign in_ready  = cnt_q != 2'd2;
    assign out_valid = cnt_q != 2'd0;
    assign push      = in_valid & in_ready;
    assign pop       = out_valid & out_ready;
    assign new_e     = {err, imm, in_tag};
    assign {out_err, imm_out, out_tag} = h_q;
    always_comb begin
        cnt_d = cnt_q + {1'b0, push} - {1'b0, pop};
        h_d   = (push && (cnt_q == 2'd0 || pop)) ? new_e : (pop && cnt_q == 2'd2) ? k_q : h_q;
        k_d   = (push && !pop && cnt_q == 2'd1) ? new_e : k_q;
    end
    always_ff @(posedge CLK) begin
        if (RESET) begin
            cnt_q <= 2'd0;
            h_q   <= '0;
            k_q   <= '0;
        end else if (FLUSH) begin
            cnt_q <= 2'd0;
        end else begin
            cnt_q <= cnt_d;
            h_q   <= h_d;
            k_q   <= k_d;
        end
    end
endmodule

// File: tb/tb_imm_gen_stage.sv
// tb_imm_gen_stage: drives XLEN=32 and XLEN=64 instances in lockstep and scoreboards both
// against an arithmetic reference of the immediate formats and a FIFO occupancy model.
module tb_imm_gen_stage;
    typedef struct packed {
        logic [31:0] i32;
        logic [63:0] i64;
        logic        err;
        logic [31:0] tag;
    } exp_t;

    logic        CLK = 1'b0;
    logic        RESET = 1'b1, FLUSH = 1'b0, in_valid = 1'b0, out_ready = 1'b0;
    logic [24:0] instr_bits = '0;
    logic [2:0]  imm_sel = '0;
    logic [31:0] in_tag = '0;
    logic        ir32, ir64, ov32, ov64, err32, err64;
    logic [31:0] imm32, tag32, tag64;
    logic [63:0] imm64;

    exp_t q[$];
    bit   acc = 1'b0;
    bit   after_rst = 1'b1;
    int   vectors = 0, miscompares = 0;

    always #5 CLK = ~CLK;

    imm_gen_stage #(.XLEN(32), .TAG_W(32)) u32 (
        .CLK(CLK), .RESET(RESET), .FLUSH(FLUSH), .in_valid(in_valid), .in_ready(ir32),
        .instr_bits(instr_bits), .imm_sel(imm_sel), .in_tag(in_tag), .out_valid(ov32),
        .out_ready(out_ready), .imm_out(imm32), .out_tag(tag32), .out_err(err32)
    );
    imm_gen_stage #(.XLEN(64), .TAG_W(32)) u64 (
        .CLK(CLK), .RESET(RESET), .FLUSH(FLUSH), .in_valid(in_valid), .in_ready(ir64),
        .instr_bits(instr_bits), .imm_sel(imm_sel), .in_tag(in_tag), .out_valid(ov64),
        .out_ready(out_ready), .imm_out(imm64), .out_tag(tag64), .out_err(err64)
    );

    task automatic chk(input string n, input logic [63:0] a, input logic [63:0] e);
        vectors++;
        if (a !== e) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h at %0t", n, a, e, $time);
        end
    endtask

    // Reference: sign-extended arithmetic on the whole instruction word, then field assembly.
    function automatic exp_t model(input logic [31:0] ins, input logic [2:0] sel, input logic [31:0] tag);
        exp_t   r;
        longint s, t;
        logic [63:0] v;
        s = longint'($signed(ins));
        v = 64'd0;
        case (sel)
            3'd0: v = s >>> 20;
            3'd1: begin t = s >>> 25; v = (t << 5) | 64'(ins[11:7]); end
            3'd2: begin t = s >>> 31; v = (t << 12) | (64'(ins[7]) << 11) | (64'(ins[30:25]) << 5) | (64'(ins[11:8]) << 1); end
            3'd3: begin t = s >>> 12; v = t << 12; end
            3'd4: begin t = s >>> 31; v = (t << 20) | (64'(ins[19:12]) << 12) | (64'(ins[20]) << 11) | (64'(ins[30:21]) << 1); end
            3'd5: v = 64'(ins[19:15]);
            default: v = 64'd0;
        endcase
        r.i64 = (sel == 3'd6) ? 64'(ins[25:20]) : v;
        r.i32 = (sel == 3'd6) ? 32'(ins[24:20]) : v[31:0];
        r.err = sel == 3'd7;
        r.tag = tag;
        return r;
    endfunction

    task automatic drive(input logic v, input logic [31:0] ins, input logic [2:0] sel, input logic [31:0] tag,
                         input logic ordy, input logic fl, input logic rs, input exp_t e);
        @(posedge CLK);
        #1;
        in_valid   = v;
        instr_bits = ins[31:7];
        imm_sel    = sel;
        in_tag     = tag;
        out_ready  = ordy;
        FLUSH      = fl;
        RESET      = rs;
        acc        = 1'b0;
        #1;
        if (v && ir32 && !fl && !rs) begin
            q.push_back(e);
            acc = 1'b1;
        end
    endtask

    task automatic cyc(input logic v, input logic [31:0] ins, input logic [2:0] sel, input logic [31:0] tag,
                       input logic ordy, input logic fl, input logic rs);
        drive(v, ins, sel, tag, ordy, fl, rs, model(ins, sel, tag));
    endtask

    task automatic sendx(input logic [31:0] ins, input logic [2:0] sel, input logic [31:0] tag,
                         input logic [31:0] x32, input logic [63:0] x64, input logic xerr, input logic ordy);
        exp_t e;
        e.i32 = x32; e.i64 = x64; e.err = xerr; e.tag = tag;
        drive(1'b1, ins, sel, tag, ordy, 1'b0, 1'b0, e);
    endtask

    // Monitor: flags against model occupancy; head data compared every cycle it is valid.
    initial begin
        int occ;
        forever begin
            @(negedge CLK);
            occ = q.size() - int'(acc);
            if (!RESET) begin
                chk("out_valid32", 64'(ov32), 64'(occ != 0));
                chk("out_valid64", 64'(ov64), 64'(occ != 0));
                chk("in_ready32", 64'(ir32), 64'(occ != 2));
                chk("in_ready64", 64'(ir64), 64'(occ != 2));
                if (ov32 && occ != 0) begin
                    chk("imm32", 64'(imm32), 64'(q[0].i32));
                    chk("imm64", imm64, q[0].i64);
                    chk("tag32", 64'(tag32), 64'(q[0].tag));
                    chk("tag64", 64'(tag64), 64'(q[0].tag));
                    chk("err32", 64'(err32), 64'(q[0].err));
                    chk("err64", 64'(err64), 64'(q[0].err));
                    if (out_ready) void'(q.pop_front());
                end else if (occ == 0 && after_rst) begin
                    chk("rst_imm32", 64'(imm32), 64'd0);
                    chk("rst_imm64", imm64, 64'd0);
                    chk("rst_tag", 64'({tag32, tag64}), 64'd0);
                    chk("rst_err", 64'({err32, err64}), 64'd0);
                end
                if (acc) after_rst = 1'b0;
            end
            if (RESET) after_rst = 1'b1;
            if (RESET || FLUSH) q.delete();
        end
    end

    initial begin
        drive(1'b0, 0, 0, 0, 1'b0, 1'b0, 1'b1, '0);
        drive(1'b0, 0, 0, 0, 1'b0, 1'b0, 1'b1, '0);
        cyc(1'b0, 0, 0, 0, 1'b1, 1'b0, 1'b0);
        // Directed format vectors
        sendx(32'hFFF00093, 3'd0, 32'h11, 32'hFFFFFFFF, 64'hFFFFFFFFFFFFFFFF, 1'b0, 1'b1);
        cyc(1'b0, 0, 0, 0, 1'b1, 1'b0, 1'b0);
        sendx(32'hFE000EE3, 3'd2, 32'h12, 32'hFFFFFFFC, 64'hFFFFFFFFFFFFFFFC, 1'b0, 1'b1);
        sendx(32'hFE000EE3, 3'd3, 32'h13, 32'hFE000000, 64'hFFFFFFFFFE000000, 1'b0, 1'b1);
        sendx(32'hFE000EE3, 3'd4, 32'h14, 32'hFFF007E0, 64'hFFFFFFFFFFF007E0, 1'b0, 1'b1);
        sendx(32'h800F8000, 3'd5, 32'h15, 32'h0000001F, 64'h1F, 1'b0, 1'b1);
        sendx(32'h03F00000, 3'd6, 32'h16, 32'h0000001F, 64'h3F, 1'b0, 1'b1);
        sendx(32'h80000000, 3'd3, 32'h17, 32'h80000000, 64'hFFFFFFFF80000000, 1'b0, 1'b1);
        sendx(32'hFFFFFFFF, 3'd7, 32'h18, 32'h0, 64'h0, 1'b1, 1'b1);
        cyc(1'b0, 0, 0, 0, 1'b1, 1'b0, 1'b0);
        // Backpressure: A, B accepted, C held until space frees up
        cyc(1'b1, 32'h00A00000, 3'd0, 32'hA, 1'b0, 1'b0, 1'b0);
        cyc(1'b1, 32'h00B00000, 3'd0, 32'hB, 1'b0, 1'b0, 1'b0);
        repeat (3) cyc(1'b1, 32'h00C00000, 3'd0, 32'hC, 1'b0, 1'b0, 1'b0);
        chk("c_held", 64'(q.size()), 64'd2);
        repeat (3) cyc(1'b1, 32'h00C00000, 3'd0, 32'hC, 1'b1, 1'b0, 1'b0);
        cyc(1'b0, 0, 0, 0, 1'b1, 1'b0, 1'b0);
        // Flush with a full buffer and a same-cycle input
        cyc(1'b1, 32'h12345000, 3'd1, 32'h51, 1'b0, 1'b0, 1'b0);
        cyc(1'b1, 32'h23456000, 3'd2, 32'h52, 1'b0, 1'b0, 1'b0);
        cyc(1'b1, 32'h34567000, 3'd3, 32'hDEAD, 1'b0, 1'b1, 1'b0);
        cyc(1'b0, 0, 0, 0, 1'b1, 1'b0, 1'b0);
        cyc(1'b0, 0, 0, 0, 1'b1, 1'b0, 1'b0);
        // Reset mid-stream with a full buffer
        cyc(1'b1, 32'hABCDE000, 3'd4, 32'h61, 1'b0, 1'b0, 1'b0);
        cyc(1'b1, 32'hBCDEF000, 3'd0, 32'h62, 1'b0, 1'b0, 1'b0);
        cyc(1'b1, 32'hCDEF0000, 3'd1, 32'h63, 1'b0, 1'b0, 1'b1);
        cyc(1'b0, 0, 0, 0, 1'b0, 1'b0, 1'b0);
        cyc(1'b1, 32'h7FF00000, 3'd0, 32'h64, 1'b1, 1'b0, 1'b0);
        cyc(1'b1, 32'h80100000, 3'd0, 32'h65, 1'b1, 1'b0, 1'b0);
        cyc(1'b0, 0, 0, 0, 1'b1, 1'b0, 1'b0);
        // Random traffic with occasional flush and reset
        for (int n = 0; n < 2000; n++)
            cyc(1'($urandom_range(0, 3) != 0), $urandom, 3'($urandom_range(0, 7)), $urandom,
                1'($urandom_range(0, 2) != 0), 1'($urandom_range(0, 49) == 0), 1'($urandom_range(0, 199) == 0));
        for (int n = 0; n < 20 && q.size() != 0; n++) cyc(1'b0, 0, 0, 0, 1'b1, 1'b0, 1'b0);
        chk("drain", 64'(q.size()), 64'd0);
        @(posedge CLK);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
